// File: rtl/program_counter.sv
// program_counter: instruction address register, HERE latch and memory address mux.
// Optional PC_TRACE_EN adds last_pc, the PC_A value before the most recent commit.
module program_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        decode,
  input  logic        execute,
  input  logic        commit,
  input  logic        hold,
  input  logic [1:0]  pc_offsetx,
  input  logic [1:0]  pc_basex,
  input  logic [1:0]  addr_busx,
  input  logic [15:0] din,
  input  logic [15:0] regb_dout,
  input  logic [15:0] data_addr,
  output logic [15:0] pc_a,
  output logic [15:0] here,
  output logic [15:0] addr,
`ifdef PC_TRACE_EN
  output logic [15:0] last_pc,
`endif
  output logic        align_fault
);
  logic [15:0] base, offset, pc_next;
  logic commit_en, decode_en;
  always_comb begin
    offset    = pc_offsetx == 2'b00 ? 16'h0000 :
                pc_offsetx == 2'b01 ? 16'h0002 :
                pc_offsetx == 2'b10 ? 16'h0004 : din;
    base      = pc_basex == 2'b01 ? regb_dout :
                pc_basex == 2'b10 ? 16'h0000 : pc_a;
    pc_next   = base + offset;
    addr      = fetch ? pc_a :
                addr_busx == 2'b01 ? here :
                addr_busx == 2'b10 ? data_addr : pc_a;
    commit_en = commit & ~hold;
    // execute owns the cycle when it coincides with decode, so HERE stays put
    decode_en = decode & ~execute & ~commit & ~hold;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_a        <= 16'h0000;
      here        <= 16'h0002;
      align_fault <= 1'b0;
`ifdef PC_TRACE_EN
      last_pc     <= 16'h0000;
`endif
    end else if (commit_en) begin
      pc_a        <= {pc_next[15:1], 1'b0};
      align_fault <= align_fault | pc_next[0];
`ifdef PC_TRACE_EN
      last_pc     <= pc_a;
`endif
    end else if (decode_en) begin
      here        <= pc_a + 16'd2;
    end
  end
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 FETCH, DECODE, EXECUTE, COMMIT  input  1 each  instruction phase strobes from the sequencer.
REQ-005 HOLD  input  1  bus wait; freezes all register updates while high.
REQ-006 PC_OFFSETX  input  2  offset select: 00=0, 01=2, 10=4, 11=DIN.
REQ-007 PC_BASEX  input  2  base select: 00=PC_A, 01=REGB_DOUT, 10=0, 11=reserved (treated as PC_A).
REQ-008 ADDR_BUSX  input  2  address select: 00=PC_A, 01=HERE, 10=DATA_ADDR, 11=reserved (treated as PC_A).
REQ-009 DIN  input  16  memory read data (immediate / indirect target).
REQ-010 REGB_DOUT  input  16  register file port B data.
REQ-011 DATA_ADDR  input  16  ALU-computed data address.
REQ-012 PC_A  output  16  current instruction address.
REQ-013 HERE  output  16  address of the word following the opcode (PC_A+2).
REQ-014 ADDR  output  16  memory address bus.
REQ-015 ALIGN_FAULT  output  1  sticky flag, odd jump target.

Function
REQ-016 PC_NEXT SHALL be combinational: base(PC_BASEX) + offset(PC_OFFSETX), modulo 2^16.
REQ-017 On a COMMIT cycle with HOLD low, PC_A SHALL load {PC_NEXT[15:1],1'b0}.
REQ-018 On a DECODE cycle with HOLD low, HERE SHALL load PC_A+2 (wraps 0xFFFE -> 0x0000).
REQ-019 HERE SHALL hold its value through EXECUTE and COMMIT so that HERE-relative targets use the pre-commit PC.
REQ-020 ADDR SHALL be combinational from ADDR_BUSX, with zero-cycle latency.
REQ-021 During FETCH, ADDR SHALL equal PC_A regardless of ADDR_BUSX.
REQ-022 If PC_NEXT[0]=1 on a committing cycle, ALIGN_FAULT SHALL set and remain set until reset.
REQ-023 While HOLD is high, PC_A, HERE and ALIGN_FAULT SHALL not change; ADDR SHALL continue to track its select.
REQ-024 Multiple phase strobes in one cycle SHALL be resolved with priority COMMIT > EXECUTE > DECODE > FETCH; only the winning phase's update SHALL occur.
REQ-025 With no strobe active, all registers SHALL hold.

Reset
REQ-026 RESET SHALL immediately force PC_A=0x0000, HERE=0x0002 and ALIGN_FAULT=0, independent of CLK.
REQ-027 Reset asserted mid-instruction SHALL abandon any pending commit; after reset release, the first FETCH SHALL present ADDR=0x0000.
REQ-028 RESET SHALL override HOLD.

Configuration
REQ-029 When PC_TRACE_EN is defined, the block SHALL add the output LAST_PC[15:0], which loads the old PC_A on every committing cycle and resets to 0x0000.
REQ-030 When PC_TRACE_EN is undefined, LAST_PC and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then FETCH/DECODE/EXECUTE/COMMIT with OFFSETX=01 and BASEX=00 -> PC_A=0x0002, HERE=0x0002.
REQ-032 PC_A=0x0100; DECODE; COMMIT with OFFSETX=11, BASEX=00, DIN=0x0020 -> PC_A=0x0120, HERE=0x0102 during the commit.
REQ-033 PC_A=0xFFFE; DECODE -> HERE=0x0000; COMMIT with OFFSETX=01 -> PC_A=0x0000.
REQ-034 COMMIT with BASEX=01, REGB_DOUT=0x1235, OFFSETX=00 -> PC_A=0x1234 and ALIGN_FAULT=1, which persists across the next commit.
REQ-035 HOLD=1 through COMMIT, then HOLD=0 with COMMIT still high -> PC_A updates only on the second edge.
REQ-036 RESET pulsed between EXECUTE and COMMIT with PC_A=0x0400 -> PC_A=0x0000 asynchronously, and no update from the following strobe.
